// File: rtl/sound_latch_bridge.sv
// Main/sound 68K mailbox: command latch0 (main->sound), reply latch1 (sound->main).
// Byte-lane writes, registered reads, per-side DTACK, command IRQ to the sound CPU.
module sound_latch_port #(
  parameter int DTACK_WAIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic as_n,
  input  logic uds_n,
  input  logic lds_n,
  output logic start,
  output logic dtack_n
);
  localparam logic [2:0] WAIT = 3'(DTACK_WAIT);

  logic       active;
  logic       active_q, active_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dtack_n_q, dtack_n_d;

  assign active = cs & ~as_n & (~uds_n | ~lds_n);
  assign start  = active & ~active_q;

  // DTACK falls when the counter expires and stays low until the cycle ends
  always_comb begin
    active_d  = active;
    cnt_d     = cnt_q;
    dtack_n_d = 1'b1;
    if (start) begin
      cnt_d = WAIT;
    end else if (active && active_q) begin
      if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1 || !dtack_n_q) dtack_n_d = 1'b0;
    end else begin
      cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= 1'b0;
      cnt_q     <= 3'd0;
      dtack_n_q <= 1'b1;
    end else begin
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      dtack_n_q <= dtack_n_d;
    end
  end

  assign dtack_n = dtack_n_q;
endmodule

module sound_latch_bridge #(
  parameter int DTACK_WAIT   = 2,
  parameter bit IRQ_ON_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68kp_latch0_cs,
  input  logic        m68kp_latch1_cs,
  input  logic        m68kp_as_n,
  input  logic        m68kp_rw,
  input  logic        m68kp_uds_n,
  input  logic        m68kp_lds_n,
  input  logic [15:0] m68kp_din,
  output logic [15:0] m68kp_dout,
  output logic        m68kp_dtack_n,
  input  logic        m68ks_latch0_cs,
  input  logic        m68ks_latch1_cs,
  input  logic        m68ks_as_n,
  input  logic        m68ks_rw,
  input  logic        m68ks_uds_n,
  input  logic        m68ks_lds_n,
  input  logic [15:0] m68ks_din,
  output logic [15:0] m68ks_dout,
  output logic        m68ks_dtack_n,
  input  logic        m68ks_iack,
  output logic        m68ks_irq,
  output logic        latch0_full,
  output logic        latch1_full,
  output logic [1:0]  overrun
);
  logic p_start, s_start;

  sound_latch_port #(.DTACK_WAIT(DTACK_WAIT)) u_pport (
    .clk     (clk),
    .reset   (reset),
    .cs      (m68kp_latch0_cs | m68kp_latch1_cs),
    .as_n    (m68kp_as_n),
    .uds_n   (m68kp_uds_n),
    .lds_n   (m68kp_lds_n),
    .start   (p_start),
    .dtack_n (m68kp_dtack_n)
  );

  sound_latch_port #(.DTACK_WAIT(DTACK_WAIT)) u_sport (
    .clk     (clk),
    .reset   (reset),
    .cs      (m68ks_latch0_cs | m68ks_latch1_cs),
    .as_n    (m68ks_as_n),
    .uds_n   (m68ks_uds_n),
    .lds_n   (m68ks_lds_n),
    .start   (s_start),
    .dtack_n (m68ks_dtack_n)
  );

  // latch0_cs takes priority if a side asserts both selects
  logic p_wr0, p_rd0, p_rd1;
  logic s_wr1, s_rd0, s_rd1;

  assign p_wr0 = p_start & ~m68kp_rw & m68kp_latch0_cs;
  assign p_rd0 = p_start & m68kp_rw & m68kp_latch0_cs;
  assign p_rd1 = p_start & m68kp_rw & ~m68kp_latch0_cs & m68kp_latch1_cs;
  assign s_wr1 = s_start & ~m68ks_rw & ~m68ks_latch0_cs & m68ks_latch1_cs;
  assign s_rd0 = s_start & m68ks_rw & m68ks_latch0_cs;
  assign s_rd1 = s_start & m68ks_rw & ~m68ks_latch0_cs & m68ks_latch1_cs;

  logic [15:0] latch0_q, latch0_d;
  logic [15:0] latch1_q, latch1_d;
  logic [15:0] pdout_q, pdout_d;
  logic [15:0] sdout_q, sdout_d;
  logic        full0_q, full0_d;
  logic        full1_q, full1_d;
  logic [1:0]  ovr_q, ovr_d;
  logic        irq_q, irq_d;

  always_comb begin
    latch0_d = latch0_q;
    latch1_d = latch1_q;
    if (p_wr0) begin
      if (!m68kp_uds_n) latch0_d[15:8] = m68kp_din[15:8];
      if (!m68kp_lds_n) latch0_d[7:0]  = m68kp_din[7:0];
    end
    if (s_wr1) begin
      if (!m68ks_uds_n) latch1_d[15:8] = m68ks_din[15:8];
      if (!m68ks_lds_n) latch1_d[7:0]  = m68ks_din[7:0];
    end
  end

  // Reads see the pre-write value; a same-clock write keeps the latch full
  always_comb begin
    pdout_d = pdout_q;
    sdout_d = sdout_q;
    if (p_rd0) pdout_d = latch0_q;
    if (p_rd1) pdout_d = latch1_q;
    if (s_rd0) sdout_d = latch0_q;
    if (s_rd1) sdout_d = latch1_q;

    full0_d = full0_q;
    full1_d = full1_q;
    if (s_rd0) full0_d = 1'b0;
    if (p_wr0) full0_d = 1'b1;
    if (p_rd1) full1_d = 1'b0;
    if (s_wr1) full1_d = 1'b1;

    ovr_d[0] = ovr_q[0] | (p_wr0 & full0_q);
    ovr_d[1] = ovr_q[1] | (s_wr1 & full1_q);

    irq_d = irq_q;
    if (m68ks_iack || s_rd0) irq_d = 1'b0;
    if (p_wr0 && IRQ_ON_WRITE) irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch0_q <= 16'h0000;
      latch1_q <= 16'h0000;
      pdout_q  <= 16'h0000;
      sdout_q  <= 16'h0000;
      full0_q  <= 1'b0;
      full1_q  <= 1'b0;
      ovr_q    <= 2'b00;
      irq_q    <= 1'b0;
    end else begin
      latch0_q <= latch0_d;
      latch1_q <= latch1_d;
      pdout_q  <= pdout_d;
      sdout_q  <= sdout_d;
      full0_q  <= full0_d;
      full1_q  <= full1_d;
      ovr_q    <= ovr_d;
      irq_q    <= irq_d;
    end
  end

  assign m68kp_dout  = pdout_q;
  assign m68ks_dout  = sdout_q;
  assign latch0_full = full0_q;
  assign latch1_full = full1_q;
  assign overrun     = ovr_q;
  assign m68ks_irq   = irq_q;
endmodule
